// File: rtl/mips_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// mips_multicycle_ctrl
//
// Multi-cycle control FSM for a small MIPS subset (addiu, addu, sw, jal).
// It sequences one time-shared ALU, the PC, the IR, the register file and a
// single memory port. The ALU computes PC+4 during FETCH and the operand
// result or effective address during EXEC.
//
// Parameters:
//   MEM_TIMEOUT  cycles mem_req may stay high without mem_ready before a
//                bus fault is raised (>= 2)
//   CNT_W        wait counter width; 2**CNT_W must exceed MEM_TIMEOUT
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   opcode     in   IR[31:26], valid from DECODE onward
//   funct      in   IR[5:0], only meaningful when opcode == 0
//   mem_ready  in   memory completes the current request this cycle
//   mem_req    out  memory request, held until mem_ready
//   mem_we     out  memory write strobe
//   mem_src    out  memory address select (0 = PC, 1 = ALU result register)
//   ir_we      out  load IR from memory read data
//   pc_we      out  load PC
//   pc_src     out  PC source (00 = ALU result, 01 = jump target)
//   alu_ctrl   out  ALU op (0000 addiu/PC+4, 0001 sw, 0010 addu, 0011 jal)
//   alu_src_a  out  ALU A select (0 = PC, 1 = rs)
//   alu_src_b  out  ALU B select (00 = rt, 01 = const 4, 10 = sext imm16)
//   reg_we     out  register file write enable
//   reg_dst    out  write register select (00 = rt, 01 = rd, 10 = $31)
//   reg_wsrc   out  write data select (0 = ALU result register, 1 = PC)
//   retired    out  one-cycle pulse per completed instruction
//   fault      out  sticky fault code (00 none, 01 illegal, 10 bus timeout)
// ---------------------------------------------------------------------------
module mips_multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_src,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic [3:0] alu_ctrl,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       reg_we,
    output logic [1:0] reg_dst,
    output logic       reg_wsrc,
    output logic       retired,
    output logic [1:0] fault
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_TRAP   = 3'd6;

    // Instruction classes, encoded so they match their ALU control codes.
    localparam logic [1:0] I_ADDIU = 2'd0;
    localparam logic [1:0] I_SW    = 2'd1;
    localparam logic [1:0] I_ADDU  = 2'd2;
    localparam logic [1:0] I_JAL   = 2'd3;

    localparam logic [1:0] F_NONE    = 2'b00;
    localparam logic [1:0] F_ILLEGAL = 2'b01;
    localparam logic [1:0] F_BUS     = 2'b10;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [2:0]       state, state_nxt;
    logic [1:0]       instr, instr_nxt;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic [1:0]       fault_nxt;
    logic             legal;
    logic [1:0]       decoded;

    // Classify the opcode/funct pair. Anything unlisted, including X
    // values in simulation, falls into the default arm and is illegal.
    always_comb begin
        legal   = 1'b0;
        decoded = I_ADDIU;
        case (opcode)
            6'h09: begin
                legal   = 1'b1;
                decoded = I_ADDIU;
            end
            6'h00: begin
                if (funct == 6'h21) begin
                    legal   = 1'b1;
                    decoded = I_ADDU;
                end
            end
            6'h2B: begin
                legal   = 1'b1;
                decoded = I_SW;
            end
            6'h03: begin
                legal   = 1'b1;
                decoded = I_JAL;
            end
            default: begin
                legal   = 1'b0;
                decoded = I_ADDIU;
            end
        endcase
    end

    // Next-state logic. The wait counter is zeroed on every transition into
    // FETCH or MEM and advances (saturating) on each stalled memory cycle.
    // A stall in the cycle the counter reaches MEM_TIMEOUT-1 is a bus fault,
    // but mem_ready in that same cycle still completes the access.
    always_comb begin
        state_nxt    = state;
        instr_nxt    = instr;
        wait_cnt_nxt = wait_cnt;
        fault_nxt    = fault;
        case (state)
            S_IDLE: begin
                state_nxt    = S_FETCH;
                wait_cnt_nxt = '0;
            end
            S_FETCH, S_MEM: begin
                if (mem_ready) begin
                    state_nxt    = (state == S_FETCH) ? S_DECODE : S_FETCH;
                    wait_cnt_nxt = '0;
                end else if (wait_cnt == CNT_LAST) begin
                    state_nxt = S_TRAP;
                    fault_nxt = F_BUS;
                end else if (wait_cnt != CNT_MAX) begin
                    wait_cnt_nxt = wait_cnt + 1'b1;
                end
            end
            S_DECODE: begin
                if (legal) begin
                    state_nxt = S_EXEC;
                    instr_nxt = decoded;
                end else begin
                    state_nxt = S_TRAP;
                    fault_nxt = F_ILLEGAL;
                end
            end
            S_EXEC: begin
                wait_cnt_nxt = '0;
                case (instr)
                    I_SW:    state_nxt = S_MEM;
                    I_JAL:   state_nxt = S_FETCH;
                    default: state_nxt = S_WB;
                endcase
            end
            S_WB: begin
                state_nxt    = S_FETCH;
                wait_cnt_nxt = '0;
            end
            S_TRAP: begin
                state_nxt = S_TRAP;
            end
            default: begin
                state_nxt    = S_IDLE;
                wait_cnt_nxt = '0;
            end
        endcase
    end

    // State registers; reset returns to IDLE and clears counter and fault.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            instr    <= I_ADDIU;
            wait_cnt <= '0;
            fault    <= F_NONE;
        end else begin
            state    <= state_nxt;
            instr    <= instr_nxt;
            wait_cnt <= wait_cnt_nxt;
            fault    <= fault_nxt;
        end
    end

    // Moore output decode. Only the IR/PC loads in FETCH and the retire
    // pulse in MEM look at mem_ready, so a stalled access never commits.
    // Because these are pure decodes of state, an asserted reset forces
    // every control output low immediately.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_src   = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_src    = 2'b00;
        alu_ctrl  = 4'b0000;
        alu_src_a = 1'b0;
        alu_src_b = 2'b00;
        reg_we    = 1'b0;
        reg_dst   = 2'b00;
        reg_wsrc  = 1'b0;
        retired   = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    ir_we = 1'b1;
                    pc_we = 1'b1;
                end
            end
            S_EXEC: begin
                alu_ctrl = {2'b00, instr};
                case (instr)
                    I_ADDU: begin
                        alu_src_a = 1'b1;
                        alu_src_b = 2'b00;
                    end
                    I_ADDIU, I_SW: begin
                        alu_src_a = 1'b1;
                        alu_src_b = 2'b10;
                    end
                    default: begin
                        // jal: PC already holds PC+4, so it is linked into $31
                        pc_we    = 1'b1;
                        pc_src   = 2'b01;
                        reg_we   = 1'b1;
                        reg_dst  = 2'b10;
                        reg_wsrc = 1'b1;
                        retired  = 1'b1;
                    end
                endcase
            end
            S_WB: begin
                reg_we  = 1'b1;
                reg_dst = (instr == I_ADDU) ? 2'b01 : 2'b00;
                retired = 1'b1;
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                mem_src = 1'b1;
                if (mem_ready) begin
                    retired = 1'b1;
                end
            end
            default: begin
                mem_req = 1'b0;
            end
        endcase
    end

endmodule
